// File: rtl/vector_ops_pipe.sv
// vector_ops_pipe: pipelined vector-ops block with a 2-entry output skid buffer.
// Each accepted word produces:
//  - a reduction selected by in_mode (AND/OR/XOR/XNOR over all WIDTH bits),
//  - a SLICE_W-bit field starting at SLICE_LSB,
//  - a bit-reversed copy,
//  - a popcount, only when VEC_POPCNT_EN is defined.
// Without VEC_POPCNT_EN the out_popcnt port and its storage do not exist.
//
// Handshake (both sides): a beat transfers on a rising edge where valid && ready.
//  - in_ready and out_valid are registered decodes of the buffer state.
//    Neither depends combinationally on in_valid or out_ready.
//  - A source offering a word while in_ready=0 must hold it until it is taken.
//  - Output fields are stable while out_valid=1 and out_ready=0.
module vector_ops_pipe #(
  parameter int WIDTH     = 8,
  parameter int SLICE_LSB = 0,
  parameter int SLICE_W   = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [WIDTH-1:0]              in_data,
  input  logic [1:0]                    in_mode,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic                          out_reduce,
  output logic [SLICE_W-1:0]            out_slice,
  output logic [WIDTH-1:0]              out_rev,
`ifdef VEC_POPCNT_EN
  output logic [$clog2(WIDTH+1)-1:0]    out_popcnt,
`endif
  output logic                          out_valid,
  input  logic                          out_ready
);

`ifdef VEC_POPCNT_EN
  localparam int CW = $clog2(WIDTH+1);
`endif

  // Buffer occupancy; state is the debug view of the skid buffer.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t state;

  logic in_ready_q;
  logic out_valid_q;

  // Head entry drives the outputs directly; tail holds the skid word.
  logic               head_reduce;
  logic [SLICE_W-1:0] head_slice;
  logic [WIDTH-1:0]   head_rev;
  logic               tail_reduce;
  logic [SLICE_W-1:0] tail_slice;
  logic [WIDTH-1:0]   tail_rev;
`ifdef VEC_POPCNT_EN
  logic [CW-1:0]      head_popcnt;
  logic [CW-1:0]      tail_popcnt;
  logic [CW-1:0]      new_popcnt;
`endif

  logic               new_reduce;
  logic [SLICE_W-1:0] new_slice;
  logic [WIDTH-1:0]   new_rev;

  logic push;
  logic pop;

  assign push = in_valid && in_ready_q;
  assign pop  = out_valid_q && out_ready;

  // Mode-selected reduction and field extraction of the incoming word.
  always_comb begin
    new_reduce = 1'b0;
    case (in_mode)
      2'b00:   new_reduce = &in_data;
      2'b01:   new_reduce = |in_data;
      2'b10:   new_reduce = ^in_data;
      default: new_reduce = ~(^in_data);
    endcase
    new_slice = in_data[SLICE_LSB +: SLICE_W];
  end

  // Bit reversal: new_rev[i] takes in_data[WIDTH-1-i].
  always_comb begin
    new_rev = '0;
    for (int i = 0; i < WIDTH; i++) begin
      new_rev[i] = in_data[WIDTH-1-i];
    end
  end

`ifdef VEC_POPCNT_EN
  // Count of ones in the incoming word.
  always_comb begin
    new_popcnt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      new_popcnt = new_popcnt + CW'(in_data[i]);
    end
  end
`endif

  // Skid-buffer FSM with registered ready/valid.
  // in_ready_q stays low through reset and rises on the first edge after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= EMPTY;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      head_reduce <= 1'b0;
      head_slice  <= '0;
      head_rev    <= '0;
      tail_reduce <= 1'b0;
      tail_slice  <= '0;
      tail_rev    <= '0;
`ifdef VEC_POPCNT_EN
      head_popcnt <= '0;
      tail_popcnt <= '0;
`endif
    end else begin
      case (state)
        EMPTY: begin
          in_ready_q <= 1'b1;
          if (push) begin
            head_reduce <= new_reduce;
            head_slice  <= new_slice;
            head_rev    <= new_rev;
`ifdef VEC_POPCNT_EN
            head_popcnt <= new_popcnt;
`endif
            state       <= ONE;
            out_valid_q <= 1'b1;
          end else begin
            out_valid_q <= 1'b0;
          end
        end
        ONE: begin
          if (push && pop) begin
            // The head leaves and the new word replaces it.
            head_reduce <= new_reduce;
            head_slice  <= new_slice;
            head_rev    <= new_rev;
`ifdef VEC_POPCNT_EN
            head_popcnt <= new_popcnt;
`endif
          end else if (push) begin
            tail_reduce <= new_reduce;
            tail_slice  <= new_slice;
            tail_rev    <= new_rev;
`ifdef VEC_POPCNT_EN
            tail_popcnt <= new_popcnt;
`endif
            state       <= TWO;
            in_ready_q  <= 1'b0;
          end else if (pop) begin
            // Head fields are left as-is; out_valid=0 marks them stale.
            state       <= EMPTY;
            out_valid_q <= 1'b0;
          end
        end
        TWO: begin
          if (pop) begin
            head_reduce <= tail_reduce;
            head_slice  <= tail_slice;
            head_rev    <= tail_rev;
`ifdef VEC_POPCNT_EN
            head_popcnt <= tail_popcnt;
`endif
            state       <= ONE;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state       <= EMPTY;
          in_ready_q  <= 1'b0;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_reduce = head_reduce;
  assign out_slice  = head_slice;
  assign out_rev    = head_rev;
`ifdef VEC_POPCNT_EN
  assign out_popcnt = head_popcnt;
`endif

endmodule

// File: tb/tb_vector_ops_pipe.sv
// tb_vector_ops_pipe: directed bench for vector_ops_pipe (WIDTH=8, SLICE_LSB=0, SLICE_W=4).
// Popcount checks are active when VEC_POPCNT_EN is defined.
module tb_vector_ops_pipe;

  localparam logic [1:0] M_AND  = 2'b00;
  localparam logic [1:0] M_OR   = 2'b01;
  localparam logic [1:0] M_XOR  = 2'b10;
  localparam logic [1:0] M_XNOR = 2'b11;

  logic       clk;
  logic       rst_n;
  logic [7:0] in_data;
  logic [1:0] in_mode;
  logic       in_valid;
  logic       in_ready;
  logic       out_reduce;
  logic [3:0] out_slice;
  logic [7:0] out_rev;
`ifdef VEC_POPCNT_EN
  logic [3:0] out_popcnt;
`endif
  logic       out_valid;
  logic       out_ready;

  int checks = 0;
  int errors = 0;

  // Scoreboard entry: {reduce, slice, rev, popcnt}.
  logic [16:0] exp_q[$];

  vector_ops_pipe #(
    .WIDTH(8),
    .SLICE_LSB(0),
    .SLICE_W(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_data(in_data),
    .in_mode(in_mode),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .out_reduce(out_reduce),
    .out_slice(out_slice),
    .out_rev(out_rev),
`ifdef VEC_POPCNT_EN
    .out_popcnt(out_popcnt),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  // Clock and global time limit.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  function automatic logic [16:0] mk(input logic r, input logic [3:0] s,
                                     input logic [7:0] v, input logic [3:0] p);
`ifdef VEC_POPCNT_EN
    return {r, s, v, p};
`else
    return {r, s, v, 4'd0 & p};
`endif
  endfunction

  // Scoreboard: every transfer on the output side must match the queue head.
  always @(negedge clk) begin
    logic [16:0] obs;
    logic [16:0] exp;
    if (rst_n && out_valid && out_ready) begin
`ifdef VEC_POPCNT_EN
      obs = {out_reduce, out_slice, out_rev, out_popcnt};
`else
      obs = {out_reduce, out_slice, out_rev, 4'd0};
`endif
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output: got %h, expected nothing", obs);
      end else begin
        exp = exp_q.pop_front();
        if (obs !== exp) begin
          errors++;
          $display("FAIL output_word: got %h, expected %h", obs, exp);
        end
      end
    end
  end

  // Driver: offer a word and hold it until accepted. Returns 1ns after the accepting edge.
  task automatic send(input logic [7:0] d, input logic [1:0] m);
    int n;
    n = 0;
    in_data  = d;
    in_mode  = m;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready=%b, expected 1 within 50 cycles", in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Driver: wait until the scoreboard has seen every expected word.
  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      n++;
      @(posedge clk);
      #2;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d words outstanding, expected 0", name, exp_q.size());
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'hF3;
    in_mode   = M_XOR;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL reset_handshake: out_valid=%b in_ready=%b, expected 0 0", out_valid, in_ready);
      end
      checks++;
      if (out_reduce !== 1'b0 || out_slice !== 4'h0 || out_rev !== 8'h00) begin
        errors++;
        $display("FAIL reset_results: reduce=%b slice=%h rev=%h, expected 0 0 00",
                 out_reduce, out_slice, out_rev);
      end
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: out_valid=%b in_ready=%b, expected 0 1", out_valid, in_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    exp_q.push_back(mk(1'b0, 4'h3, 8'hCF, 4'd6));
    send(8'hF3, M_XOR);
    checks++;
    if (out_valid !== 1'b1 || out_rev !== 8'hCF || out_slice !== 4'h3 || out_reduce !== 1'b0) begin
      errors++;
      $display("FAIL basic_latency: valid=%b reduce=%b slice=%h rev=%h, expected 1 0 3 cf",
               out_valid, out_reduce, out_slice, out_rev);
    end
    drain("basic");
    checks++;
    if (out_valid !== 1'b0 || out_rev !== 8'hCF) begin
      errors++;
      $display("FAIL basic_stale_hold: valid=%b rev=%h, expected 0 cf", out_valid, out_rev);
    end
  endtask

  task automatic test_back_to_back();
    time t0;
    exp_q.push_back(mk(1'b0, 4'hA, 8'h55, 4'd4));
    exp_q.push_back(mk(1'b1, 4'h5, 8'hAA, 4'd4));
    exp_q.push_back(mk(1'b1, 4'hD, 8'hB6, 4'd5));
    t0 = $time;
    send(8'hAA, M_AND);
    send(8'h55, M_OR);
    send(8'h6D, M_XOR);
    checks++;
    if ($time - t0 > 40) begin
      errors++;
      $display("FAIL b2b_rate: three words took %0t, expected at most 40", $time - t0);
    end
    drain("b2b");
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    exp_q.push_back(mk(1'b0, 4'h3, 8'hCF, 4'd6));
    exp_q.push_back(mk(1'b0, 4'hA, 8'h55, 4'd4));
    exp_q.push_back(mk(1'b1, 4'h5, 8'hAA, 4'd4));
    send(8'hF3, M_XOR);
    send(8'hAA, M_AND);
    in_data  = 8'h55;
    in_mode  = M_OR;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL bp_full: in_ready=%b out_valid=%b, expected 0 1", in_ready, out_valid);
      end
      checks++;
      if (out_rev !== 8'hCF || out_slice !== 4'h3 || out_reduce !== 1'b0) begin
        errors++;
        $display("FAIL bp_stable: reduce=%b slice=%h rev=%h, expected 0 3 cf",
                 out_reduce, out_slice, out_rev);
      end
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(8'h55, M_OR);
    drain("bp");
  endtask

  task automatic test_reduce_modes();
    exp_q.push_back(mk(1'b0, 4'hC, 8'h3F, 4'd6));
    exp_q.push_back(mk(1'b1, 4'hC, 8'h3F, 4'd6));
    exp_q.push_back(mk(1'b1, 4'hF, 8'hFF, 4'd8));
    exp_q.push_back(mk(1'b1, 4'hC, 8'h3F, 4'd6));
    send(8'hFC, M_AND);
    send(8'hFC, M_OR);
    send(8'hFF, M_AND);
    send(8'hFC, M_XNOR);
    drain("modes");
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    send(8'h6D, M_XOR);
    send(8'hAA, M_AND);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL mid_full: in_ready=%b out_valid=%b, expected 0 1", in_ready, out_valid);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_async_reset: out_valid=%b in_ready=%b, expected 0 0", out_valid, in_ready);
    end
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    exp_q.push_back(mk(1'b1, 4'h5, 8'hAA, 4'd4));
    send(8'h55, M_OR);
    drain("mid");
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_no_leftover: out_valid=%b, expected 0", out_valid);
    end
  endtask

  initial begin
    in_data   = '0;
    in_mode   = '0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    rst_n     = 1'b0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_backpressure();
    test_reduce_modes();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
